// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - bus UART controller with TX/RX byte FIFOs and a TX drain FSM
// Optional interrupt port and CTRL register enabled by UART_FIFO_IRQ_EN.
module uart_fifo_ctrl #(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data
`ifdef UART_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam int TXF = 0;
  localparam int RXF = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txState_t;

  txState_t state, nextState;

  logic [1:0]       fPush, fPop, fEmpty, fFull;
  logic [7:0]       fPushData [2];
  logic [7:0]       fHead [2];
  logic [FIFO_AW:0] fCount [2];

  logic        accept, dataWr, dataRd, statRd;
  logic        rxOvr, txOvf, txIdle;
  logic [31:0] status, readMux;

`ifdef UART_FIFO_IRQ_EN
  logic ieRx, ieTx;
`endif

  assign accept = bus_req & ~bus_ack;
  assign dataWr = accept & bus_we & (bus_addr == 2'd0);
  assign dataRd = accept & ~bus_we & (bus_addr == 2'd0);
  assign statRd = accept & ~bus_we & (bus_addr == 2'd1);

  // TX writes are dropped when full even if the drain pops that cycle.
  assign fPush[TXF]     = dataWr & ~fFull[TXF];
  assign fPop[TXF]      = (state == START);
  assign fPushData[TXF] = bus_wdata;
  assign fPush[RXF]     = rx_ready;
  assign fPop[RXF]      = dataRd;
  assign fPushData[RXF] = rx_data;

  for (genvar f = 0; f < 2; f++) begin : gFifo
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr, rdPtr;
    logic [FIFO_AW:0]   cnt;
    logic               popOk, pushOk;

    assign popOk     = fPop[f] & ~fEmpty[f];
    assign pushOk    = fPush[f] & (~fFull[f] | popOk);
    assign fEmpty[f] = (cnt == '0);
    assign fFull[f]  = (cnt == CNT_FULL);
    assign fCount[f] = cnt;
    assign fHead[f]  = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wrPtr <= '0;
        rdPtr <= '0;
        cnt   <= '0;
      end else begin
        if (pushOk) wrPtr <= wrPtr + 1'b1;
        if (popOk)  rdPtr <= rdPtr + 1'b1;
        if (pushOk && !popOk)      cnt <= cnt + 1'b1;
        else if (popOk && !pushOk) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr] <= fPushData[f];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE:      if (!fEmpty[TXF] && !tx_busy) nextState = START;
      START: begin
        tx_start  = 1'b1;
        tx_data   = fHead[TXF];
        nextState = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) nextState = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Sticky error flags: a set in the same cycle as the STATUS-read clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxOvr <= 1'b0;
      txOvf <= 1'b0;
    end else begin
      rxOvr <= (rx_ready & fFull[RXF] & ~dataRd) | (rxOvr & ~statRd);
      txOvf <= (dataWr & fFull[TXF]) | (txOvf & ~statRd);
    end
  end

  assign txIdle = fEmpty[TXF] & (state == IDLE) & ~tx_busy;

  always_comb begin
    status                  = '0;
    status[0]               = ~fEmpty[RXF];
    status[1]               = fFull[TXF];
    status[2]               = txIdle;
    status[3]               = rxOvr;
    status[4]               = txOvf;
    status[8 +: FIFO_AW+1]  = fCount[RXF];
    status[16 +: FIFO_AW+1] = fCount[TXF];
  end

  always_comb begin
    readMux = '0;
    case (bus_addr)
      2'd0:    readMux = fEmpty[RXF] ? 32'h0 : {24'h0, fHead[RXF]};
      2'd1:    readMux = status;
`ifdef UART_FIFO_IRQ_EN
      2'd2:    readMux = {30'h0, ieTx, ieRx};
`endif
      default: readMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= accept;
      bus_rdata <= (accept && !bus_we) ? readMux : 32'h0;
    end
  end

`ifdef UART_FIFO_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ieRx <= 1'b0;
      ieTx <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (accept && bus_we && bus_addr == 2'd2) begin
        ieRx <= bus_wdata[0];
        ieTx <= bus_wdata[1];
      end
      irq <= (ieRx & ~fEmpty[RXF]) | (ieTx & fEmpty[TXF]);
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - directed table and sequence checks for uart_fifo_ctrl
module tb_uart_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [7:0]  bus_wdata = 8'h00;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
`ifdef UART_FIFO_IRQ_EN
  logic        irq;
`endif

  uart_fifo_ctrl #(.FIFO_AW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .rx_ready(rx_ready),
    .rx_data(rx_data)
`ifdef UART_FIFO_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transmitter model: busy from one cycle after tx_start for ten cycles.
  logic       holdBusy = 1'b0;
  logic       modelBusy = 1'b0;
  int         busyCnt = 0;
  int         lastFall = -100;
  logic       prevStart = 1'b0;
  logic [7:0] txLog[$];

  assign tx_busy = holdBusy | modelBusy;

  always @(negedge clk) begin
    if (tx_start) begin
      check("start_gap", 32'(prevStart), 32'h0);
      check("start_after_busy", 32'(cyc - lastFall >= 2), 32'h1);
      txLog.push_back(tx_data);
      busyCnt = 10;
    end else if (busyCnt > 0) begin
      busyCnt--;
      if (busyCnt == 0) lastFall = cyc;
    end
    modelBusy = (busyCnt != 0);
    prevStart = tx_start;
  end

  task automatic busXfer(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                         input logic hold, output logic [31:0] rd);
    @(negedge clk);
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    @(negedge clk);
    check("bus_ack", 32'(bus_ack), 32'h1);
    rd = bus_rdata;
    if (hold) @(negedge clk);
    bus_req = 1'b0;
    bus_we  = 1'b0;
  endtask

  task automatic rxPulse(input logic [7:0] d);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic readExp(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    busXfer(1'b0, addr, 8'h00, 1'b0, rd);
    check(name, rd, exp);
  endtask

  task automatic waitLog(input string name, input int want, input int budget);
    int n = 0;
    while (txLog.size() < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(txLog.size()), 32'(want));
  endtask

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 rx pulse
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  function automatic vec_t mk(input int k, input logic [1:0] a, input logic [7:0] d,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.kind = k;
    v.addr = a;
    v.data = d;
    v.exp  = e;
    v.name = n;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n;

    vecs.push_back(mk(1, 2'd1, 8'h00, 32'h0000_0004, "stat_reset"));
    vecs.push_back(mk(1, 2'd2, 8'h00, 32'h0000_0000, "ctrl_reset"));
    vecs.push_back(mk(1, 2'd3, 8'h00, 32'h0000_0000, "addr3_read"));
    vecs.push_back(mk(0, 2'd3, 8'hFF, 32'h0000_0000, "addr3_write"));
    vecs.push_back(mk(1, 2'd3, 8'h00, 32'h0000_0000, "addr3_after_wr"));
    vecs.push_back(mk(1, 2'd0, 8'h00, 32'h0000_0000, "data_empty"));
    vecs.push_back(mk(2, 2'd0, 8'h55, 32'h0000_0000, "rx55"));
    vecs.push_back(mk(2, 2'd0, 8'hAA, 32'h0000_0000, "rxAA"));
    vecs.push_back(mk(1, 2'd1, 8'h00, 32'h0000_0205, "stat_rx2"));
    vecs.push_back(mk(1, 2'd0, 8'h00, 32'h0000_0055, "data_55"));
    vecs.push_back(mk(1, 2'd0, 8'h00, 32'h0000_00AA, "data_AA"));
    vecs.push_back(mk(1, 2'd0, 8'h00, 32'h0000_0000, "data_drained"));
    vecs.push_back(mk(1, 2'd1, 8'h00, 32'h0000_0004, "stat_rx0"));
    vecs.push_back(mk(0, 2'd1, 8'hFF, 32'h0000_0000, "stat_write"));
    vecs.push_back(mk(1, 2'd1, 8'h00, 32'h0000_0004, "stat_after_wr"));

    #2;
    check("rst_bus_ack", 32'(bus_ack), 32'h0);
    check("rst_bus_rdata", bus_rdata, 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
`ifdef UART_FIFO_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        0: busXfer(1'b1, vecs[i].addr, vecs[i].data, 1'b0, rd);
        1: readExp(vecs[i].name, vecs[i].addr, vecs[i].exp);
        default: rxPulse(vecs[i].data);
      endcase
    end

    // Three bytes through the drain FSM
    busXfer(1'b1, 2'd0, 8'h41, 1'b0, rd);
    @(negedge clk);
    check("tx_start_latency", 32'(tx_start), 32'h1);
    check("tx_data_latency", 32'(tx_data), 32'h41);
    busXfer(1'b1, 2'd0, 8'h42, 1'b0, rd);
    busXfer(1'b1, 2'd0, 8'h43, 1'b0, rd);
    waitLog("tx3_count", 3, 200);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) check("tx3_byte", 32'(txLog[i]), 32'(8'h41 + i));
    readExp("stat_tx_idle", 2'd1, 32'h0000_0004);

    // RX overrun and same-cycle push/pop on a full FIFO
    for (int i = 0; i < 17; i++) rxPulse(8'(8'h10 + i));
    readExp("stat_rx_ovr", 2'd1, 32'h0000_100D);
    readExp("stat_rx_ovr_clr", 2'd1, 32'h0000_1005);
    @(negedge clk);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 2'd0;
    rx_ready = 1'b1;
    rx_data  = 8'h99;
    @(negedge clk);
    rx_ready = 1'b0;
    check("same_cycle_ack", 32'(bus_ack), 32'h1);
    check("same_cycle_data", bus_rdata, 32'h10);
    bus_req = 1'b0;
    readExp("stat_same_cycle", 2'd1, 32'h0000_1005);
    for (int i = 1; i < 16; i++) readExp("rx_order", 2'd0, 32'(8'h10 + i));
    readExp("rx_last_99", 2'd0, 32'h99);
    readExp("stat_rx_empty", 2'd1, 32'h0000_0004);

    // TX overflow with transmitter held busy
    holdBusy = 1'b1;
    txLog.delete();
    for (int i = 0; i < 17; i++) busXfer(1'b1, 2'd0, 8'(8'h60 + i), 1'b0, rd);
    readExp("stat_tx_ovf", 2'd1, 32'h0010_0012);
    readExp("stat_tx_ovf_clr", 2'd1, 32'h0010_0002);
    holdBusy = 1'b0;
    waitLog("tx16_count", 16, 600);
    repeat (40) @(negedge clk);
    check("tx17_dropped", 32'(txLog.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("tx16_byte", 32'(txLog[i]), 32'(8'h60 + i));
    readExp("stat_tx16_idle", 2'd1, 32'h0000_0004);

    // Held request accepted once, then reset mid-drain
    holdBusy = 1'b1;
    txLog.delete();
    busXfer(1'b1, 2'd0, 8'h71, 1'b1, rd);
    busXfer(1'b1, 2'd0, 8'h72, 1'b0, rd);
    busXfer(1'b1, 2'd0, 8'h73, 1'b0, rd);
    readExp("stat_tx3_held", 2'd1, 32'h0003_0000);
    holdBusy = 1'b0;
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_drain_start", 32'(tx_start), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_tx_start", 32'(tx_start), 32'h0);
    check("rstmid_tx_data", 32'(tx_data), 32'h0);
    check("rstmid_bus_ack", 32'(bus_ack), 32'h0);
    check("rstmid_bus_rdata", bus_rdata, 32'h0);
`ifdef UART_FIFO_IRQ_EN
    check("rstmid_irq", 32'(irq), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    readExp("stat_after_rst", 2'd1, 32'h0000_0004);
    check("rst_discarded_tx", 32'(txLog.size()), 32'd1);

`ifdef UART_FIFO_IRQ_EN
    busXfer(1'b1, 2'd2, 8'h01, 1'b0, rd);
    readExp("ctrl_rw", 2'd2, 32'h1);
    check("irq_idle", 32'(irq), 32'h0);
    rxPulse(8'h5A);
    check("irq_not_yet", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_rx_high", 32'(irq), 32'h1);
    readExp("irq_data", 2'd0, 32'h5A);
    check("irq_still_high", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_rx_low", 32'(irq), 32'h0);
    busXfer(1'b1, 2'd2, 8'h02, 1'b0, rd);
    @(negedge clk);
    check("irq_tx_empty", 32'(irq), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Bus-facing UART controller between the OpenMIPS peripheral bus and the UART async transmitter and receiver. It buffers outgoing bytes in a TX FIFO and drains them into the transmitter through a start/busy handshake. It captures received bytes from the receiver's one-cycle ready pulse into an RX FIFO. Software sees a data register, a status register and an optional interrupt-control register.

## Interface
- `FIFO_AW`, default 4: FIFO address width; each FIFO holds 2^FIFO_AW bytes (16).
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bus_req`  in  1  transaction request; held high by the master until `bus_ack`.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
- `bus_wdata`  in  8  write data.
- `bus_rdata`  out  32  read data; valid while `bus_ack` is high.
- `bus_ack`  out  1  one-cycle completion strobe.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte for the transmitter; valid with `tx_start`.
- `tx_busy`  in  1  transmitter busy.
- `rx_ready`  in  1  one-cycle byte-valid pulse from the receiver.
- `rx_data`  in  8  received byte; sampled when `rx_ready` is high.
- `irq`  out  1  interrupt request; present only when UART_FIFO_IRQ_EN is defined.

## Operation
- FIFOs: circular buffers with wrapping read and write pointers and a FIFO_AW+1-bit count. Full means count == 2^FIFO_AW; empty means count == 0. A push and a pop in the same cycle both take effect and leave count unchanged. A pop while empty, or a push while full, changes nothing.
- DATA write: pushes `bus_wdata[7:0]` into the TX FIFO. If the TX FIFO is full, the byte is dropped and the sticky `tx_ovf` flag is set.
- DATA read: returns {24'b0, RX head} and pops the RX FIFO. If the RX FIFO is empty, it returns 0 with no pop.
- STATUS read (writes ignored):
  - bit0 `rx_avail`; bit1 `tx_full`; bit2 `tx_idle` (TX FIFO empty, drain FSM in IDLE and `tx_busy` low).
  - bit3 `rx_ovr`; bit4 `tx_ovf`.
  - [12:8] RX count; [20:16] TX count; all other bits 0.
  - The read returns the flags as they stand, then clears bits 3 and 4. If a flag sets in the same cycle as the clear, the set wins.
- CTRL: bit0 `ie_rx`, bit1 `ie_tx`; read/write. Address 3 reads 0 and ignores writes.
- RX capture: when `rx_ready` is high, `rx_data` is pushed. If the RX FIFO is full and no DATA read pops in the same cycle, the byte is dropped and `rx_ovr` is set.
- TX drain FSM, registered:
  - IDLE → START when the TX FIFO is non-empty and `tx_busy` == 0.
  - START: `tx_start` = 1 with `tx_data` = FIFO head; the head is popped; → WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when `tx_busy` == 1.
  - WAIT_DONE → IDLE when `tx_busy` == 0.
- Reset: all outputs 0, FIFOs empty, flags and CTRL 0, FSM in IDLE. Asserting `rst_n` low mid-frame aborts the drain and discards both FIFOs immediately. The transmitter completes any frame already in flight on its own.

## Timing
- The bus request is sampled when `bus_req` is high and `bus_ack` is low. `bus_ack` and `bus_rdata` are registered and appear exactly 1 cycle later, for 1 cycle. Side effects (push, pop, flag clear) occur on the sampling edge. A request held into the ack cycle is not re-accepted.
- Byte written to an empty TX FIFO while IDLE: count rises at edge N; FSM enters START at N+1; `tx_start` is high during cycle N+1 to N+2. Next byte: `tx_start` no earlier than 2 cycles after `tx_busy` falls.
- `rx_ready` at edge N: byte is readable by a request sampled at edge N+1 or later.
- `tx_start` is never high in two consecutive cycles.

## Configuration
- `UART_FIFO_IRQ_EN` defined: the `irq` port exists. `irq` is registered: `irq` = (`ie_rx` & `rx_avail`) | (`ie_tx` & TX FIFO empty), updated each cycle, reset 0.
- Not defined: no `irq` port or logic; the CTRL register reads 0 and ignores writes.

## Test plan
- Write 0x41, 0x42, 0x43 to DATA with a transmitter model (busy from 1 cycle after start for 10 cycles) → three `tx_start` pulses with `tx_data` 0x41, 0x42, 0x43 in order; STATUS bit2 = 1 afterwards.
- Pulse `rx_ready` with 0x55, then 0xAA → STATUS shows `rx_avail` = 1 and RX count 2; DATA reads return 0x55, 0xAA, then 0 with `rx_avail` = 0.
- 17 `rx_ready` pulses with no reads → count 16 and STATUS bit3 = 1; a second STATUS read shows bit3 = 0; the first 16 bytes are intact.
- 17 DATA writes while `tx_busy` is held high → STATUS bit1 = 1 and bit4 = 1, TX count 16; the 17th byte is never transmitted.
- Same-cycle `rx_ready` and DATA read on a full RX FIFO → no overrun, count stays 16, FIFO order preserved; drop `rst_n` mid-drain → all outputs 0 the same cycle and STATUS reads 0x00000004 after release.
- With UART_FIFO_IRQ_EN defined: CTRL = 0x1, then one `rx_ready` → `irq` high 1 cycle later; a DATA read emptying the FIFO → `irq` low the following cycle.
